// File: rtl/proc_control.sv
// -----------------------------------------------------------------------------
// proc_control
//
// Multicycle control unit for the 16-bit bus-based processor. It fetches a
// 9-bit instruction from DIN and then walks the shared datapath through each
// step. Every step drives one-hot bus-source and load strobes for the register
// file, the A and G registers, and the ALU function code.
//
// Instruction word (IR[8:0]):
//   [8:6] opcode  000 mv  Rx <- Ry        100 or   Rx <- Rx | Ry
//                 001 mvi Rx <- DIN       101 slt  Rx <- Rx < Ry
//                 010 add Rx <- Rx + Ry   110 sll  Rx <- Rx << Ry
//                 011 sub Rx <- Rx - Ry   111 srl  Rx <- Rx >> Ry
//   [5:3] Rx,  [2:0] Ry
//
// Step sequence (T0 is idle/fetch):
//   mv    T1: Rout[Ry], Rin[Rx], Done
//   mvi   T1: DINout,   Rin[Rx], Done
//   alu   T1: Rout[Rx], Ain
//         T2: Rout[Ry], Gin, AluOp
//         T3: Gout,     Rin[Rx], Done
//
// Ports:
//   Clock   in   1  system clock, rising-edge
//   Reset   in   1  asynchronous, active-high; returns to T0 and clears IR
//   Run     in   1  start request, sampled only in T0
//   DIN     in  16  instruction source in T0 (bits 8:0), immediate for mvi
//   Rout    out  8  one-hot register-to-bus enable
//   Gout    out  1  G-to-bus enable
//   DINout  out  1  DIN-to-bus enable
//   Rin     out  8  one-hot register load enable (from bus)
//   Ain     out  1  A register load enable (from bus)
//   Gin     out  1  G register load enable (from ALU)
//   AluOp   out  3  ALU function code, nonzero only in T2
//   Done    out  1  single-cycle instruction-complete pulse
// -----------------------------------------------------------------------------
module proc_control (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic [7:0]  Rout,
    output logic        Gout,
    output logic        DINout,
    output logic [7:0]  Rin,
    output logic        Ain,
    output logic        Gin,
    output logic [2:0]  AluOp,
    output logic        Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [2:0] rx;
        logic [2:0] ry;
    } instr_t;

    state_t state, nstate;
    instr_t ir;

    // Only the low nine bits of DIN carry the instruction; the upper bits are
    // consumed by the datapath as immediate data, never by this block.
    logic unused_din_hi;
    assign unused_din_hi = ^DIN[15:9];

    // Register number to one-hot bus/load select.
    function automatic logic [7:0] reg_sel(input logic [2:0] r);
        return 8'b0000_0001 << r;
    endfunction

    // ALU function code for the arithmetic/logic opcodes. The mapping happens
    // to be opcode-2, but it is spelled out so the ALU encoding can move
    // independently of the instruction encoding.
    function automatic logic [2:0] alu_code(input opcode_t op);
        logic [2:0] code;
        code = 3'b000;
        case (op)
            OP_ADD:  code = 3'b000;
            OP_SUB:  code = 3'b001;
            OP_OR:   code = 3'b010;
            OP_SLT:  code = 3'b011;
            OP_SLL:  code = 3'b100;
            OP_SRL:  code = 3'b101;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // mv and mvi finish in T1; everything else uses the A/G three-step path.
    logic is_move;
    assign is_move = (ir.op == OP_MV) || (ir.op == OP_MVI);

    // -------------------------------------------------------------------------
    // State and instruction register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= nstate;
            // IR is written only on the fetch edge, so DIN/Run activity while
            // an instruction is in flight cannot disturb its decode.
            if (state == T0 && Run)
                ir <= instr_t'(DIN[8:0]);
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore output decode
    // -------------------------------------------------------------------------
    // Outputs depend only on state and IR. Because Reset clears the state
    // register asynchronously, every strobe drops in the same cycle that
    // Reset rises, and T0 decodes to all-zero.
    always_comb begin
        nstate = state;
        Rout   = 8'h00;
        Gout   = 1'b0;
        DINout = 1'b0;
        Rin    = 8'h00;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AluOp  = 3'b000;
        Done   = 1'b0;

        unique case (state)
            T0: begin
                if (Run)
                    nstate = T1;
            end

            T1: begin
                if (ir.op == OP_MV) begin
                    Rout   = reg_sel(ir.ry);
                    Rin    = reg_sel(ir.rx);
                    Done   = 1'b1;
                    nstate = T0;
                end else if (ir.op == OP_MVI) begin
                    DINout = 1'b1;
                    Rin    = reg_sel(ir.rx);
                    Done   = 1'b1;
                    nstate = T0;
                end else begin
                    // First operand into A.
                    Rout   = reg_sel(ir.rx);
                    Ain    = 1'b1;
                    nstate = T2;
                end
            end

            T2: begin
                // Second operand on the bus; ALU result captured in G.
                // A move never reaches T2; bail to idle defensively.
                if (is_move) begin
                    nstate = T0;
                end else begin
                    Rout   = reg_sel(ir.ry);
                    Gin    = 1'b1;
                    AluOp  = alu_code(ir.op);
                    nstate = T3;
                end
            end

            T3: begin
                // Write G back to Rx.
                if (!is_move) begin
                    Gout = 1'b1;
                    Rin  = reg_sel(ir.rx);
                    Done = 1'b1;
                end
                nstate = T0;
            end

            default: nstate = T0;
        endcase
    end

endmodule
